// File: rtl/cache_mem_arbiter.sv
// Shares one single-word RAM port between the icache and dcache controllers.
// Dcache wins by default; a saturating starve counter forces an icache grant.
//
// state | meaning
// IDLE  | no access in flight; arbitrate among pending requests
// IGNT  | icache owns the RAM port, waiting for ram_ready
// DGNT  | dcache owns the RAM port, waiting for ram_ready
module cache_mem_arbiter #(
  parameter int IWAIT_MAX = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready
);

  localparam int SW = $clog2(IWAIT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] starve, starve_nxt;
  logic          dreq;
  logic          starved;
  logic          i_done;
  logic          d_done;

  assign dreq    = dREN | dWEN;
  assign starved = (starve >= SW'(IWAIT_MAX));
  // A completion only counts while the owner still holds its request.
  assign i_done  = (state == IGNT) & iREN & ram_ready;
  assign d_done  = (state == DGNT) & dreq & ram_ready;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      starve <= '0;
    end else begin
      state  <= state_nxt;
      starve <= starve_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve;
    case (state)
      IDLE: begin
        if (!iREN) starve_nxt = '0;
        if (starved && iREN)  state_nxt = IGNT;
        else if (dreq)        state_nxt = DGNT;
        else if (iREN)        state_nxt = IGNT;
      end
      IGNT: begin
        if (!iREN) begin
          state_nxt = IDLE;
        end else if (ram_ready) begin
          state_nxt  = IDLE;
          starve_nxt = '0;
        end
      end
      DGNT: begin
        if (!dreq) begin
          state_nxt = IDLE;
        end else if (ram_ready) begin
          state_nxt = IDLE;
          if (iREN && !starved) starve_nxt = starve + SW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes follow the owner's live request so an abort drops them immediately.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      IGNT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
      end
      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
      end
      default: ;
    endcase
  end

  assign iload = ramload;
  assign dload = ramload;
  assign iwait = iREN & ~i_done;
  assign dwait = dreq & ~d_done;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of memory contents and grant fairness.
module tb_cache_mem_arbiter;

  localparam int IWAIT_MAX = 8;
  localparam int OWN_NONE = 0, OWN_I = 1, OWN_D = 2;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN, ram_ready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN;

  int checks = 0;
  int errors = 0;

  cache_mem_arbiter #(.IWAIT_MAX(IWAIT_MAX)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Holds both requests and completes every access at once; returns how many
  // dcache grants occurred before the icache address appeared on the port.
  task automatic run_to_igrant(output int n, output bit found);
    n = 0;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      step();
      ram_ready = 1'b0;
      #1;
      if (ramREN | ramWEN) begin
        ram_ready = 1'b1;
        if (ramaddr == iaddr) found = 1'b1;
        else n++;
        #1;
      end
    end
  endtask

  task automatic test_reset();
    nRST = 1'b1; iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 32'h1234_5678;
    #2 nRST = 1'b0;
    #1;
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL reset_ramREN: got %b want 0", ramREN); end
    checks++; if (ramWEN !== 1'b0) begin errors++; $display("FAIL reset_ramWEN: got %b want 0", ramWEN); end
    checks++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin errors++; $display("FAIL reset_addr_store: got %h/%h want 0/0", ramaddr, ramstore); end
    checks++; if (iwait !== 1'b0 || dwait !== 1'b0) begin errors++; $display("FAIL reset_waits: got %b/%b want 0/0", iwait, dwait); end
    checks++; if (iload !== 32'h1234_5678 || dload !== 32'h1234_5678) begin errors++; $display("FAIL reset_passthrough: got %h/%h want 12345678", iload, dload); end
    repeat (3) step();
    nRST = 1'b1;
    step();
  endtask

  task automatic test_icache_only();
    iREN = 1'b1; iaddr = 32'h40;
    #1;
    checks++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin errors++; $display("FAIL ionly_c0: ramREN=%b iwait=%b want 0/1", ramREN, iwait); end
    step();
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h40 || iwait !== 1'b1) begin errors++; $display("FAIL ionly_c1: ramREN=%b addr=%h iwait=%b want 1/40/1", ramREN, ramaddr, iwait); end
    step();
    ram_ready = 1'b1; ramload = 32'hA5A5_0040;
    #1;
    checks++; if (iwait !== 1'b0 || iload !== 32'hA5A5_0040) begin errors++; $display("FAIL ionly_c2: iwait=%b iload=%h want 0/a5a50040", iwait, iload); end
    step();
    ram_ready = 1'b0; iREN = 1'b0;
    #1;
    checks++; if (ramREN !== 1'b0 || iwait !== 1'b0) begin errors++; $display("FAIL ionly_c3: ramREN=%b iwait=%b want 0/0", ramREN, iwait); end
    step();
  endtask

  task automatic test_priority();
    iREN = 1'b1; iaddr = 32'h200; dREN = 1'b1; daddr = 32'h100;
    step();
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h100 || iwait !== 1'b1 || dwait !== 1'b1) begin errors++; $display("FAIL prio_dgnt: ramREN=%b addr=%h iwait=%b dwait=%b want 1/100/1/1", ramREN, ramaddr, iwait, dwait); end
    ram_ready = 1'b1; ramload = 32'h0D0D_0100;
    #1;
    checks++; if (dwait !== 1'b0 || dload !== 32'h0D0D_0100 || iwait !== 1'b1) begin errors++; $display("FAIL prio_dcomp: dwait=%b dload=%h iwait=%b want 0/0d0d0100/1", dwait, dload, iwait); end
    step();
    ram_ready = 1'b0; dREN = 1'b0;
    #1;
    checks++; if ((ramREN | ramWEN) !== 1'b0 || iwait !== 1'b1) begin errors++; $display("FAIL prio_bubble: strobe=%b iwait=%b want 0/1", ramREN | ramWEN, iwait); end
    step();
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h200) begin errors++; $display("FAIL prio_ignt: ramREN=%b addr=%h want 1/200", ramREN, ramaddr); end
    ram_ready = 1'b1;
    #1;
    checks++; if (iwait !== 1'b0) begin errors++; $display("FAIL prio_icomp: iwait=%b want 0", iwait); end
    step();
    ram_ready = 1'b0; iREN = 1'b0;
    step();
  endtask

  task automatic test_write();
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h80; dstore = 32'hDEAD_BEEF;
    step();
    checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'hDEAD_BEEF || ramaddr !== 32'h80) begin errors++; $display("FAIL write: WEN=%b REN=%b store=%h addr=%h want 1/0/deadbeef/80", ramWEN, ramREN, ramstore, ramaddr); end
    ram_ready = 1'b1;
    #1;
    checks++; if (dwait !== 1'b0) begin errors++; $display("FAIL write_done: dwait=%b want 0", dwait); end
    step();
    ram_ready = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    step();
  endtask

  task automatic test_starve();
    int  n;
    bit  found;
    iREN = 1'b1; iaddr = 32'h300; dREN = 1'b1; daddr = 32'h500;
    for (int r = 0; r < 2; r++) begin
      run_to_igrant(n, found);
      checks++; if (!found || n != IWAIT_MAX) begin errors++; $display("FAIL starve_round%0d: found=%b dgrants=%0d want 1/%0d", r, found, n, IWAIT_MAX); end
      checks++; if (iwait !== 1'b0) begin errors++; $display("FAIL starve_icomp%0d: iwait=%b want 0", r, iwait); end
    end
    step();
    ram_ready = 1'b0; iREN = 1'b0; dREN = 1'b0;
    step();
  endtask

  task automatic test_abort();
    dREN = 1'b1; daddr = 32'h600;
    step();
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h600) begin errors++; $display("FAIL abort_grant: ramREN=%b addr=%h want 1/600", ramREN, ramaddr); end
    step();
    dREN = 1'b0; ram_ready = 1'b1;
    #1;
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || dwait !== 1'b0) begin errors++; $display("FAIL abort_drop: REN=%b WEN=%b dwait=%b want 0/0/0", ramREN, ramWEN, dwait); end
    step();
    ram_ready = 1'b0; iREN = 1'b1; iaddr = 32'h700;
    #1;
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL abort_idle: ramREN=%b want 0", ramREN); end
    step();
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h700) begin errors++; $display("FAIL abort_next: ramREN=%b addr=%h want 1/700", ramREN, ramaddr); end
    ram_ready = 1'b1;
    step();
    ram_ready = 1'b0; iREN = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int n;
    bit found;
    iREN = 1'b1; iaddr = 32'h800;
    step();
    checks++; if (ramREN !== 1'b1) begin errors++; $display("FAIL rstmid_ignt: ramREN=%b want 1", ramREN); end
    #1 nRST = 1'b0;
    #1;
    checks++; if (ramREN !== 1'b0 || ramaddr !== 32'h0) begin errors++; $display("FAIL rstmid_async: ramREN=%b addr=%h want 0/0", ramREN, ramaddr); end
    step();
    nRST = 1'b1;
    // Build up three starved dcache completions, then reset inside DGNT.
    dREN = 1'b1; daddr = 32'h900;
    n = 0;
    for (int k = 0; k < 30 && n < 3; k++) begin
      step();
      ram_ready = 1'b0;
      #1;
      if (ramREN | ramWEN) begin ram_ready = 1'b1; n++; end
    end
    step();
    ram_ready = 1'b0;
    step();
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h900) begin errors++; $display("FAIL rstmid_dgnt: ramREN=%b addr=%h want 1/900", ramREN, ramaddr); end
    #1 nRST = 1'b0;
    #1;
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL rstmid_async_d: ramREN=%b want 0", ramREN); end
    step();
    nRST = 1'b1;
    run_to_igrant(n, found);
    checks++; if (!found || n != IWAIT_MAX) begin errors++; $display("FAIL rstmid_counter: found=%b dgrants=%0d want 1/%0d", found, n, IWAIT_MAX); end
    step();
    ram_ready = 1'b0; iREN = 1'b0; dREN = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [31:0] ram_mem [16];
    logic [31:0] ref_mem [16];
    int lat_cnt = 0, lat_tgt = 0, ipend = 0, pred = OWN_NONE, owner = OWN_NONE;
    int icomp = 0, dcomp = 0;
    bit prev_strobe = 1'b0, prev_done = 1'b0, strobe, i_done, d_done, ok;
    logic n_iren = 1'b0, n_dren = 1'b0, n_dwen = 1'b0;
    logic [31:0] n_iaddr = 0, n_daddr = 0, n_dstore = 0;
    for (int i = 0; i < 16; i++) begin
      ram_mem[i] = $urandom;
      ref_mem[i] = ram_mem[i];
    end
    for (int c = 0; c < 1500; c++) begin
      @(posedge CLK);
      #1;
      iREN = n_iren; iaddr = n_iaddr;
      dREN = n_dren; dWEN = n_dwen; daddr = n_daddr; dstore = n_dstore;
      #1;
      strobe = ramREN | ramWEN;
      if (strobe && lat_cnt >= lat_tgt) begin
        ram_ready = 1'b1; lat_cnt = 0; lat_tgt = $urandom_range(0, 2);
      end else begin
        ram_ready = 1'b0;
        lat_cnt = strobe ? lat_cnt + 1 : 0;
      end
      ramload = ramREN ? ram_mem[ramaddr[3:0]] : $urandom;
      @(negedge CLK);
      checks++; if (ramREN & ramWEN) begin errors++; $display("FAIL rnd_both_strobes: cycle %0d", c); end
      if (prev_strobe && prev_done) owner = OWN_NONE;
      else if (!prev_strobe) owner = pred;
      case (owner)
        OWN_I:   ok = ramREN && !ramWEN && ramaddr == iaddr;
        OWN_D:   ok = ramaddr == daddr && ramWEN == dWEN && ramREN == !dWEN && (!dWEN || ramstore == dstore);
        default: ok = !strobe;
      endcase
      checks++; if (!ok) begin errors++; $display("FAIL rnd_grant: cycle %0d owner=%0d REN=%b WEN=%b addr=%h", c, owner, ramREN, ramWEN, ramaddr); end
      i_done = iREN & ~iwait;
      d_done = (dREN | dWEN) & ~dwait;
      checks++; if (i_done != (owner == OWN_I && ram_ready) || (!iREN && iwait)) begin errors++; $display("FAIL rnd_iwait: cycle %0d iwait=%b owner=%0d ready=%b", c, iwait, owner, ram_ready); end
      checks++; if (d_done != (owner == OWN_D && ram_ready) || (!(dREN | dWEN) && dwait)) begin errors++; $display("FAIL rnd_dwait: cycle %0d dwait=%b owner=%0d ready=%b", c, dwait, owner, ram_ready); end
      if (ram_ready && ramWEN) ram_mem[ramaddr[3:0]] = ramstore;
      if (i_done) begin
        checks++; if (iload !== ref_mem[iaddr[3:0]]) begin errors++; $display("FAIL rnd_iload: addr %h got %h want %h", iaddr, iload, ref_mem[iaddr[3:0]]); end
        icomp++; ipend = 0;
      end
      if (d_done) begin
        if (dWEN) ref_mem[daddr[3:0]] = dstore;
        else begin
          checks++; if (dload !== ref_mem[daddr[3:0]]) begin errors++; $display("FAIL rnd_dload: addr %h got %h want %h", daddr, dload, ref_mem[daddr[3:0]]); end
        end
        dcomp++;
        if (iREN) begin
          ipend++;
          checks++; if (ipend > IWAIT_MAX) begin errors++; $display("FAIL rnd_starve: icache passed over %0d times, limit %0d", ipend, IWAIT_MAX); end
        end
      end
      prev_strobe = strobe;
      prev_done = i_done | d_done;
      if (iREN && ipend >= IWAIT_MAX) pred = OWN_I;
      else if (dREN | dWEN)           pred = OWN_D;
      else if (iREN)                  pred = OWN_I;
      else                            pred = OWN_NONE;
      if (!iREN || i_done) begin
        n_iren = ($urandom_range(0, 3) != 0);
        n_iaddr = $urandom_range(0, 15);
      end
      if (!(dREN | dWEN) || d_done) begin
        if ($urandom_range(0, 3) != 0) begin
          n_dwen = ($urandom_range(0, 2) == 0);
          n_dren = n_dwen ? 1'($urandom_range(0, 1)) : 1'b1;
        end else begin
          n_dwen = 1'b0; n_dren = 1'b0;
        end
        n_daddr = $urandom_range(0, 15);
        n_dstore = $urandom;
      end
    end
    checks++; if (icomp == 0 || dcomp == 0) begin errors++; $display("FAIL rnd_progress: icache %0d dcache %0d completions", icomp, dcomp); end
    @(posedge CLK);
    #1;
    iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
    repeat (2) step();
  endtask

  initial begin
    test_reset();
    test_icache_only();
    test_priority();
    test_write();
    test_starve();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
